jtag_spi_bridge_mc: RTL and testbench

- Parametrised successor of the JTAG-to-SPI flash bridge: a USER-chain bit stream from a BSCAN primitive is hunted for a magic header, then forwarded to one of N SPI chip-selects for a programmed number of bits.
- MISO is captured into an on-chip bit buffer and returned on TDO in the following shift session, or passed straight through.
- Sits between the BSCAN instance and SPI_ACCESS / external SPI pins.
- Entire block runs on DRCK; no logic runs on the inverted clock.

---
 rtl/jtag_spi_pkg.sv | 20 ++
 rtl/spi_bit_buffer.sv | 33 +++
 rtl/jtag_spi_bridge_mc.sv | 174 +++++++++++++++++
 tb/tb_jtag_spi_bridge_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_spi_pkg.sv
// Shared types and helpers for the JTAG-to-SPI bridge.
package jtag_spi_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ARM  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] MAGIC_DEFAULT = 32'h59A6_59A6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_bit_buffer.sv
// DEPTH x 1 simple dual-port RAM on a single clock with a registered read port.
module spi_bit_buffer
  import jtag_spi_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic mem [DEPTH];
  logic rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // The output register is reset so TDO idles low before the first read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= 1'b0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jtag_spi_bridge_mc.sv
// JTAG USER-chain to SPI bridge: hunts a magic header in the DR stream, then
// forwards TDI/MISO to the selected chip-select for a programmed bit count.
//
// state | meaning
// HUNT  | shifting TDI into the header register, waiting for the magic
// ARM   | one cycle with CS asserted, capture pointer and OVF cleared
// XFER  | SCK running while SHIFT=1, counting len down to zero
// DONE  | transfer finished (or rejected); idle until abort
module jtag_spi_bridge_mc
  import jtag_spi_pkg::*;
#(
  parameter int                 MAGIC_W = 32,
  parameter logic [MAGIC_W-1:0] MAGIC   = MAGIC_W'(MAGIC_DEFAULT),
  parameter int                 NCS     = 4,
  parameter int                 CS_W    = 2,
  parameter int                 LEN_W   = 16,
  parameter int                 DEPTH   = 16384,
  parameter int                 DIRECT  = 0
) (
  input  logic           DRCK,
  input  logic           RESET_N,
  input  logic           SEL,
  input  logic           SHIFT,
  input  logic           CAPTURE,
  input  logic           UPDATE,
  input  logic           TDI,
  output logic           TDO,
  input  logic           MISO,
  output logic           MOSI,
  output logic           SCK_EN,
  output logic [NCS-1:0] CSB,
  output logic           OVF,
  output logic           BUSY
);

  localparam int AW = clog2(DEPTH);
  // The oldest header bit leaves the register before it is ever compared,
  // so only H-1 bits need storage.
  localparam int HW = MAGIC_W + CS_W + LEN_W - 1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [CS_W:0] NCS_L   = (CS_W+1)'(NCS);

  state_e            state_q, state_d;
  logic [HW-1:0]     hdr_q, hdr_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [AW:0]       waddr_q, waddr_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;

  logic              abort;
  logic [HW:0]       hdr_next;
  logic              match;
  logic [CS_W-1:0]   cs_new;
  logic [LEN_W-1:0]  len_new;
  logic              cs_bad;

  assign abort    = CAPTURE | UPDATE | ~SEL;
  assign hdr_next = {hdr_q, TDI};
  assign match    = (hdr_next[HW -: MAGIC_W] == MAGIC);
  assign cs_new   = hdr_next[LEN_W +: CS_W];
  assign len_new  = hdr_next[LEN_W-1:0];
  assign cs_bad   = ({1'b0, cs_new} >= NCS_L);

  always_ff @(posedge DRCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= HUNT;
      hdr_q   <= '0;
      cs_q    <= '0;
      len_q   <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cs_q    <= cs_d;
      len_q   <= len_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cs_d    = cs_q;
    len_d   = len_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    if (SHIFT) raddr_d = raddr_q + 1'b1;
    if (abort) begin
      state_d = HUNT;
      hdr_d   = '0;
      raddr_d = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (SHIFT) begin
            hdr_d = hdr_next[HW-1:0];
            if (match) begin
              hdr_d   = '0;
              cs_d    = cs_new;
              len_d   = len_new;
              state_d = (len_new == '0 || cs_bad) ? DONE : ARM;
            end
          end
        end
        ARM: begin
          waddr_d = '0;
          ovf_d   = 1'b0;
          state_d = XFER;
        end
        XFER: begin
          if (SHIFT) begin
            len_d = len_q - 1'b1;
            // Capture saturates at DEPTH; excess bits are dropped and flagged.
            if (waddr_q == DEPTH_L) begin
              ovf_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              waddr_d = waddr_q + 1'b1;
            end
            if (len_q == LEN_W'(1)) state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = HUNT;
      endcase
    end
  end

  // CS and SCK decode straight from the state register so an async reset
  // releases the slave without waiting for DRCK.
  assign BUSY   = (state_q == ARM) || (state_q == XFER);
  assign SCK_EN = (state_q == XFER) && SHIFT && !abort;
  assign MOSI   = (state_q == XFER) && TDI;
  assign OVF    = ovf_q;

  always_comb begin
    CSB = '1;
    for (int i = 0; i < NCS; i++) begin
      if (BUSY && cs_q == CS_W'(i)) CSB[i] = 1'b0;
    end
  end

  if (DIRECT == 0) begin : g_buf
    spi_bit_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_buf (
      .clk_i   (DRCK),
      .rst_n_i (RESET_N),
      .we_i    (wr_en),
      .waddr_i (waddr_q[AW-1:0]),
      .wdata_i (MISO),
      .re_i    (SHIFT),
      .raddr_i (raddr_q),
      .rdata_o (TDO)
    );
  end else begin : g_direct
    logic tdo_q;
    always_ff @(posedge DRCK or negedge RESET_N) begin
      if (!RESET_N) tdo_q <= 1'b0;
      else          tdo_q <= MISO;
    end
    assign TDO = tdo_q;
  end

endmodule

// File: tb/tb_jtag_spi_bridge_mc.sv
// Directed bench for the JTAG-to-SPI bridge: buffered build with a 16-bit
// buffer plus a passthrough build sharing the same stimulus.
module tb_jtag_spi_bridge_mc;

  localparam int          H     = 51;
  localparam int          DEPTH = 16;
  localparam logic [31:0] MAGIC = 32'h59A6_59A6;

  logic drck = 1'b0;
  logic rst_n, sel, shift, capture, update, tdi, miso;
  logic tdo, mosi, sck_en, ovf, busy;
  logic [3:0] csb;
  logic tdo_x, mosi_x, sck_en_x, ovf_x, busy_x;
  logic [3:0] csb_x;

  int n_cmp = 0;
  int n_bad = 0;
  int sck_cnt;
  logic [7:0]  din;
  logic [8:0]  dpat;
  logic [39:0] mis;

  always #5 drck = ~drck;

  jtag_spi_bridge_mc #(.NCS(4), .CS_W(3), .DEPTH(DEPTH), .DIRECT(0)) u_dut (
    .DRCK(drck), .RESET_N(rst_n), .SEL(sel), .SHIFT(shift), .CAPTURE(capture),
    .UPDATE(update), .TDI(tdi), .TDO(tdo), .MISO(miso), .MOSI(mosi),
    .SCK_EN(sck_en), .CSB(csb), .OVF(ovf), .BUSY(busy)
  );

  jtag_spi_bridge_mc #(.NCS(4), .CS_W(3), .DEPTH(DEPTH), .DIRECT(1)) u_dir (
    .DRCK(drck), .RESET_N(rst_n), .SEL(sel), .SHIFT(shift), .CAPTURE(capture),
    .UPDATE(update), .TDI(tdi), .TDO(tdo_x), .MISO(miso), .MOSI(mosi_x),
    .SCK_EN(sck_en_x), .CSB(csb_x), .OVF(ovf_x), .BUSY(busy_x)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One DRCK cycle: inputs change on the falling edge, checks follow 1 time unit later.
  task automatic cyc(input logic c, input logic s, input logic u, input logic d, input logic mi);
    @(negedge drck);
    capture = c; shift = s; update = u; tdi = d; miso = mi;
    #1;
  endtask

  task automatic send_hdr(input logic [2:0] cs, input logic [15:0] len);
    logic [H-1:0] h;
    h = {MAGIC, cs, len};
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = H-1; i >= 0; i--) cyc(1'b0, 1'b1, 1'b0, h[i], 1'b0);
  endtask

  task automatic read_back(input string tag, input int n, input logic [39:0] bits);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("%s[%0d]", tag, k), 32'(tdo), 32'(bits[k % DEPTH]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; shift = 1'b0; capture = 1'b0;
    update = 1'b0; tdi = 1'b0; miso = 1'b0;
    #3;
    chk("rst_csb", 32'(csb), 32'hF);
    chk("rst_sck", 32'(sck_en), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_tdo", 32'(tdo), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tdo_dir", 32'(tdo_x), 0);
    @(negedge drck);
    rst_n = 1'b1; sel = 1'b1;

    // Basic transfer: cs=1, 8 bits of 0xA5
    din = 8'hA5;
    mis = 40'h00_0000_003C;
    send_hdr(3'd1, 16'd8);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arm_csb", 32'(csb), 32'hD);
    chk("arm_busy", 32'(busy), 1);
    chk("arm_sck", 32'(sck_en), 0);
    sck_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 1'b0, din[7-k], mis[k]);
      chk($sformatf("b_csb[%0d]", k), 32'(csb), 32'hD);
      chk($sformatf("b_mosi[%0d]", k), 32'(mosi), 32'(din[7-k]));
      if (sck_en) sck_cnt++;
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    if (sck_en) sck_cnt++;
    chk("b_done_csb", 32'(csb), 32'hF);
    chk("b_done_busy", 32'(busy), 0);
    chk("b_sck_cnt", 32'(sck_cnt), 8);
    chk("b_ovf", 32'(ovf), 0);
    read_back("b_rb", 8, mis);

    // Zero length: no CS activity, OVF untouched
    send_hdr(3'd1, 16'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("z_csb", 32'(csb), 32'hF);
      chk("z_busy", 32'(busy), 0);
      chk("z_sck", 32'(sck_en), 0);
    end

    // Out-of-range chip select
    send_hdr(3'd5, 16'd8);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("cs5_csb", 32'(csb), 32'hF);
      chk("cs5_busy", 32'(busy), 0);
    end

    // Abort with UPDATE after 40 of 100 bits
    mis = 40'hC3_5A96_E127;
    send_hdr(3'd2, 16'd100);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ab_arm_csb", 32'(csb), 32'hB);
    for (int k = 0; k < 40; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, mis[k]);
    chk("ab_busy_before", 32'(busy), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ab_upd_sck", 32'(sck_en), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ab_csb", 32'(csb), 32'hF);
    chk("ab_sck", 32'(sck_en), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ovf", 32'(ovf), 1);
    read_back("ab_rb", 40, mis);

    // Overflow: 20 bits into a 16-bit buffer
    mis = 40'h00_000B_6E4D;
    send_hdr(3'd0, 16'd20);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ov_arm_csb", 32'(csb), 32'hE);
    sck_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, mis[k]);
      if (k == 0) chk("ov_ovf_cleared", 32'(ovf), 0);
      if (sck_en) sck_cnt++;
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if (sck_en) sck_cnt++;
    chk("ov_sck_cnt", 32'(sck_cnt), 20);
    chk("ov_ovf", 32'(ovf), 1);
    chk("ov_csb", 32'(csb), 32'hF);
    read_back("ov_rb", 20, mis);

    // SHIFT pause mid-transfer; exactly DEPTH bits so no overflow
    send_hdr(3'd3, 16'd16);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sck_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      if (sck_en) sck_cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("p_csb", 32'(csb), 32'h7);
      chk("p_sck", 32'(sck_en), 0);
      chk("p_busy", 32'(busy), 1);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      if (sck_en) sck_cnt++;
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    if (sck_en) sck_cnt++;
    chk("p_sck_cnt", 32'(sck_cnt), 16);
    chk("p_done_csb", 32'(csb), 32'hF);
    chk("p_ovf", 32'(ovf), 0);

    // Async reset mid-transfer, away from any DRCK edge
    send_hdr(3'd1, 16'd8);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("ar_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_csb", 32'(csb), 32'hF);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_sck", 32'(sck_en), 0);
    chk("ar_tdo", 32'(tdo), 0);
    @(negedge drck);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar_idle_csb", 32'(csb), 32'hF);

    // Passthrough build: TDO follows MISO one cycle later
    dpat = 9'b0_1101_0010;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, dpat[0]);
    for (int k = 1; k < 9; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, dpat[k]);
      chk($sformatf("dir_tdo[%0d]", k), 32'(tdo_x), 32'(dpat[k-1]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
